bist_result_tx: RTL

Byte-stream transmitter for the end-of-run BIST result. When the BIST controller signals completion, the block snapshots the detected-error count and the total injected-fault count. It then ships them as a framed, checksummed packet over a valid/ready byte interface to the off-chip tester link. The block replaces simulation-only result printing with a hardware path, and sits after the controller's `ERR_COUNTER` output.

---
 rtl/bist_result_tx.sv | 111 +++++++++++
 1 files changed

// File: rtl/bist_result_tx.sv
// End-of-run BIST result transmitter: snapshots the error and fault counts on START
// and sends them as a SYNC-framed, XOR-checksummed byte packet over valid/ready.
module bist_result_tx #(
   parameter int          ERR_BITS = 12,
   parameter int          TOT_BITS = 12,
   parameter logic [7:0]  SYNC     = 8'hA5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                START,
   input  logic [ERR_BITS-1:0] ERR_COUNT,
   input  logic [TOT_BITS-1:0] ERR_TOTAL,
   output logic [7:0]          TX_DATA,
   output logic                TX_VALID,
   input  logic                TX_READY,
   output logic                BUSY,
   output logic                DONE
);

   localparam int NE      = (ERR_BITS + 7) / 8;
   localparam int NT      = (TOT_BITS + 7) / 8;
   localparam int L       = 2 + NE + NT;
   localparam int IDX_W   = $clog2(L);
   localparam int ERR_PAD = 8 * NE;
   localparam int TOT_PAD = 8 * NT;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   // Handshake: a byte moves on any rising edge where TX_VALID and TX_READY are both 1.
   // TX_DATA and TX_VALID are held steady until that edge; only rst may withdraw them.

   logic [0:0]         state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [7:0]         chk;
   logic [7:0]         byte_nxt;
   logic [ERR_PAD-1:0] err_snap;
   logic [TOT_PAD-1:0] tot_snap;
   logic               xfer;

   assign xfer    = (state == S_SEND) && TX_VALID && TX_READY;
   assign idx_nxt = idx + IDX_W'(1);

   // The byte that follows the one now on TX_DATA; the checksum folds in TX_DATA itself.
   always_comb begin
      byte_nxt = 8'h00;
      for (int j = 0; j < NE; j++) begin
         if (idx_nxt == IDX_W'(NE - j))
            byte_nxt = err_snap[8*j +: 8];
      end
      for (int j = 0; j < NT; j++) begin
         if (idx_nxt == IDX_W'(NE + NT - j))
            byte_nxt = tot_snap[8*j +: 8];
      end
      if (idx_nxt == IDX_W'(L - 1))
         byte_nxt = chk ^ TX_DATA;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         chk      <= 8'h00;
         err_snap <= '0;
         tot_snap <= '0;
         TX_DATA  <= 8'h00;
         TX_VALID <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  err_snap <= ERR_PAD'(ERR_COUNT);
                  tot_snap <= TOT_PAD'(ERR_TOTAL);
                  idx      <= '0;
                  chk      <= 8'h00;
                  TX_DATA  <= SYNC;
                  TX_VALID <= 1'b1;
                  BUSY     <= 1'b1;
                  state    <= S_SEND;
               end
            end
            S_SEND: begin
               if (xfer) begin
                  chk <= chk ^ TX_DATA;
                  if (idx == IDX_W'(L - 1)) begin
                     idx      <= '0;
                     TX_DATA  <= 8'h00;
                     TX_VALID <= 1'b0;
                     BUSY     <= 1'b0;
                     DONE     <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     idx     <= idx_nxt;
                     TX_DATA <= byte_nxt;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               TX_VALID <= 1'b0;
               BUSY     <= 1'b0;
            end
         endcase
      end
   end

endmodule
